// File: rtl/fbcpu_loader_if.sv
// Framed program stream into the loader: one word per valid/ready handshake.
interface fbcpu_loader_if #(
    parameter int unsigned DATA_WIDTH = 10
) ();
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;

    modport master (output i_valid, output i_data, input o_ready);
    modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/fbcpu_loader.sv
// Loads a length/payload/checksum frame into FBCPU RAM while holding the CPU in reset,
// then releases the CPU and hands the RAM port over to it.
module fbcpu_loader #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    fbcpu_loader_if.slave            i_stream,
    input  logic                     i_restart,
    input  logic                     i_cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0]    i_cpu_data,
    output logic                     o_we,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_cpu_rst,
    output logic                     o_done,
    output logic                     o_error
);
    localparam int unsigned CW    = ADDRESS_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                   r_state;
    logic                     r_ready;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_cpu_rst;
    logic                     r_done;
    logic                     r_error;
    logic [DATA_WIDTH-1:0]    r_sum;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            r_len;

    logic                     w_accept;
    logic                     w_len_ok;
    logic                     w_run;
    logic [CW-1:0]            w_cnt_next;

    assign w_accept   = i_stream.i_valid && r_ready;
    assign w_len_ok   = (i_stream.i_data != '0) && (32'(i_stream.i_data) <= DEPTH);
    assign w_cnt_next = r_cnt + CW'(1);
    assign w_run      = (r_state == S_RUN);

    assign i_stream.o_ready = r_ready;

    // Once running, the CPU owns the RAM port with no added latency.
    assign o_we      = w_run ? i_cpu_we   : r_we;
    assign o_addr    = w_run ? i_cpu_addr : r_addr;
    assign o_data    = w_run ? i_cpu_data : r_data;
    assign o_cpu_rst = r_cpu_rst;
    assign o_done    = r_done;
    assign o_error   = r_error;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_len_ok) begin
                            r_len   <= CW'(i_stream.i_data);
                            r_cnt   <= '0;
                            r_sum   <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_ready <= 1'b0;
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_cnt[ADDRESS_WIDTH-1:0];
                        r_data  <= i_stream.i_data;
                        r_sum   <= r_sum + i_stream.i_data;
                        r_cnt   <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_state <= (i_stream.i_data == r_sum) ? S_RUN : S_ERROR;
                    end
                end
                // CPU leaves reset one edge after entry, after the last payload write retired.
                S_RUN: begin
                    if (i_restart) begin
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b1;
                        r_done    <= 1'b0;
                        r_cpu_rst <= 1'b1;
                    end else begin
                        r_done    <= 1'b1;
                        r_cpu_rst <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (i_restart) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_error <= 1'b0;
                    end else begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fbcpu_loader.sv
// Directed bench for fbcpu_loader: per-cycle vector tables plus hand sequences for
// long frames, stalled frames and asynchronous reset during a load.
module tb_fbcpu_loader;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 10;

    logic          clk;
    logic          rst;
    logic          restart;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cpu_rst;
    logic          done;
    logic          error;

    fbcpu_loader_if #(.DATA_WIDTH(DW)) u_if ();

    fbcpu_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_stream   (u_if),
        .i_restart  (restart),
        .i_cpu_we   (cpu_we),
        .i_cpu_addr (cpu_addr),
        .i_cpu_data (cpu_data),
        .o_we       (we),
        .o_addr     (addr),
        .o_data     (data),
        .o_cpu_rst  (cpu_rst),
        .o_done     (done),
        .o_error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model fed by the loader's write port.
    logic [DW-1:0] ram [64];
    bit            written [64];
    int            wr_count = 0;
    always @(posedge clk) begin
        if (we === 1'b1) begin
            ram[addr]     <= data;
            written[addr] <= 1'b1;
            wr_count      <= wr_count + 1;
        end
    end

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          rs;
        logic          cwe;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          e_rdy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_crst;
        logic          e_done;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int v, int d, int rs, int cwe, int ca, int cd,
                                int rdy, int w, int a, int dd, int crst, int dn, int er);
        vec_t r;
        r.v = 1'(v);   r.d = DW'(d);  r.rs = 1'(rs);
        r.cwe = 1'(cwe); r.ca = AW'(ca); r.cd = DW'(cd);
        r.e_rdy = 1'(rdy); r.e_we = 1'(w); r.e_addr = AW'(a); r.e_data = DW'(dd);
        r.e_crst = 1'(crst); r.e_done = 1'(dn); r.e_err = 1'(er);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        u_if.i_valid = 1'b0;
        restart      = 1'b0;
        cpu_we       = 1'b0;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            u_if.i_valid = tbl[i].v;
            u_if.i_data  = tbl[i].d;
            restart      = tbl[i].rs;
            cpu_we       = tbl[i].cwe;
            cpu_addr     = tbl[i].ca;
            cpu_data     = tbl[i].cd;
            #1;
            check($sformatf("row%0d ready", i), 32'(u_if.o_ready), 32'(tbl[i].e_rdy));
            check($sformatf("row%0d we", i), 32'(we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                check($sformatf("row%0d addr", i), 32'(addr), 32'(tbl[i].e_addr));
                check($sformatf("row%0d data", i), 32'(data), 32'(tbl[i].e_data));
            end
            check($sformatf("row%0d cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].e_crst));
            check($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("row%0d error", i), 32'(error), 32'(tbl[i].e_err));
        end
        @(negedge clk);
        drive_idle();
    endtask

    // Waits (bounded) for o_ready, then returns on the accepting edge.
    task automatic send_word(input int w, input bit stall);
        int k;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                u_if.i_valid = 1'b0;
                u_if.i_data  = DW'($urandom);
            end
        end
        @(negedge clk);
        u_if.i_valid = 1'b1;
        u_if.i_data  = DW'(w);
        k = 0;
        while (u_if.o_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("ready wait", 32'(u_if.o_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic expect_run(input string name);
        @(negedge clk);
        u_if.i_valid = 1'b0;
        #1;
        check({name, " done t+0"}, 32'(done), 32'd0);
        check({name, " cpu_rst t+0"}, 32'(cpu_rst), 32'd1);
        @(negedge clk);
        #1;
        check({name, " done t+1"}, 32'(done), 32'd1);
        check({name, " cpu_rst t+1"}, 32'(cpu_rst), 32'd0);
        check({name, " ready"}, 32'(u_if.o_ready), 32'd0);
    endtask

    task automatic do_restart(input string name);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        #1;
        check({name, " restart ready"}, 32'(u_if.o_ready), 32'd1);
        check({name, " restart done"}, 32'(done), 32'd0);
        check({name, " restart cpu_rst"}, 32'(cpu_rst), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ready"}, 32'(u_if.o_ready), 32'd0);
        check({name, " we"}, 32'(we), 32'd0);
        check({name, " addr"}, 32'(addr), 32'd0);
        check({name, " data"}, 32'(data), 32'd0);
        check({name, " cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({name, " done"}, 32'(done), 32'd0);
        check({name, " error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int bad;
        rst          = 1'b0;
        restart      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = '0;
        cpu_data     = '0;
        u_if.i_valid = 1'b0;
        u_if.i_data  = '0;

        //                v  d   rs cwe ca  cd   rdy we a   d   crst dn er
        // good load 3,5,7,3,15 with one stall, then CPU pass-through and restart
        tbl.push_back(mk(1, 3,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 0
        tbl.push_back(mk(1, 5,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   1,  1, 0,  5,  1,   0, 0));
        tbl.push_back(mk(1, 7,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(1, 3,   0, 0,  0,  0,   1,  1, 1,  7,  1,   0, 0));
        tbl.push_back(mk(1, 15,  0, 0,  0,  0,   1,  1, 2,  3,  1,   0, 0));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   0,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   0,  0, 0,  0,  0,   1, 0)); // 7
        tbl.push_back(mk(0, 0,   0, 1,  52, 50,  0,  1, 52, 50, 0,   1, 0)); // 8
        tbl.push_back(mk(0, 0,   1, 0,  0,  0,   0,  0, 0,  0,  0,   1, 0));
        tbl.push_back(mk(0, 0,   0, 1,  52, 50,  1,  0, 0,  0,  1,   0, 0)); // 10
        // bad checksum 2,10,20,31; CPU write ignored in ERROR
        tbl.push_back(mk(1, 2,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 11
        tbl.push_back(mk(1, 10,  0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(1, 20,  0, 0,  0,  0,   1,  1, 0,  10, 1,   0, 0));
        tbl.push_back(mk(1, 31,  0, 0,  0,  0,   1,  1, 1,  20, 1,   0, 0));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   0,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(0, 0,   0, 1,  52, 7,   0,  0, 0,  0,  1,   0, 1));
        tbl.push_back(mk(0, 0,   1, 0,  0,  0,   0,  0, 0,  0,  1,   0, 1));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 18
        // length 0
        tbl.push_back(mk(1, 0,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 19
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   0,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(0, 0,   1, 0,  0,  0,   0,  0, 0,  0,  1,   0, 1));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 22
        // length 65
        tbl.push_back(mk(1, 65,  0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 23
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   0,  0, 0,  0,  1,   0, 0));
        tbl.push_back(mk(0, 0,   1, 0,  0,  0,   0,  0, 0,  0,  1,   0, 1));
        tbl.push_back(mk(0, 0,   0, 0,  0,  0,   1,  0, 0,  0,  1,   0, 0)); // 26

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("in reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready before first edge", 32'(u_if.o_ready), 32'd0);
        @(negedge clk);
        #1;
        check("ready after first edge", 32'(u_if.o_ready), 32'd1);

        apply_rows(0, 7);
        check("good write count", 32'(wr_count), 32'd3);
        check("good ram0", 32'(ram[0]), 32'd5);
        check("good ram1", 32'(ram[1]), 32'd7);
        check("good ram2", 32'(ram[2]), 32'd3);
        check("ram52 untouched", 32'(written[52]), 32'd0);
        apply_rows(8, 10);
        check("cpu ram52", 32'(ram[52]), 32'd50);

        apply_rows(11, 18);
        check("bad ram0", 32'(ram[0]), 32'd10);
        check("bad ram1", 32'(ram[1]), 32'd20);
        check("error cpu write dropped", 32'(ram[52]), 32'd50);

        apply_rows(19, 22);
        apply_rows(23, 26);

        // full-depth frame: 0..63, checksum 2016 mod 1024
        send_word(64, 1'b0);
        for (int i = 0; i < 64; i++) send_word(i, 1'b0);
        send_word(992, 1'b0);
        expect_run("len64");
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== DW'(i)) bad++;
        check("len64 image errors", 32'(bad), 32'd0);
        check("len64 ram63", 32'(ram[63]), 32'd63);
        do_restart("len64");

        // stalled 4-word frame
        send_word(4, 1'b1);
        send_word(100, 1'b1);
        send_word(200, 1'b1);
        send_word(300, 1'b1);
        send_word(400, 1'b1);
        send_word(1000, 1'b1);
        expect_run("stall");
        check("stall ram0", 32'(ram[0]), 32'd100);
        check("stall ram1", 32'(ram[1]), 32'd200);
        check("stall ram2", 32'(ram[2]), 32'd300);
        check("stall ram3", 32'(ram[3]), 32'd400);
        do_restart("stall");

        // async reset while a payload write is on the port
        send_word(3, 1'b0);
        send_word(11, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async rst");
        @(negedge clk);
        u_if.i_valid = 1'b0;
        rst          = 1'b1;
        send_word(2, 1'b0);
        send_word(9, 1'b0);
        send_word(8, 1'b0);
        send_word(17, 1'b0);
        expect_run("after rst");
        check("after rst ram0", 32'(ram[0]), 32'd9);
        check("after rst ram1", 32'(ram[1]), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
